// File: rtl/sync_ram_pkg.sv
// sync_ram_pkg: shared widths and word/address types for the RAM and its FIFO controller.
package sync_ram_pkg;
    localparam int RAM_ADDR_WIDTH = 8;
    localparam int RAM_DATA_WIDTH = 8;
    typedef logic [RAM_ADDR_WIDTH-1:0] addr_t;
    typedef logic [RAM_DATA_WIDTH-1:0] data_t;
endpackage

// File: rtl/sync_ram_if.sv
// sync_ram_if: address/data/strobe bundle between a RAM user (master) and the RAM (slave).
interface sync_ram_if
    import sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  wr;
    logic [DATA_WIDTH-1:0] r_data;
    modport master (output addr, output w_data, output wr, input r_data);
    modport slave (input addr, input w_data, input wr, output r_data);
endinterface

// File: rtl/sync_ram.sv
// sync_ram: single-port RAM, synchronous write with reset-clears-all, combinational read.
module sync_ram
    import sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    sync_ram_if.slave     bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    // reset wins over a same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (bus.wr) begin
            mem_q[bus.addr] <= bus.w_data;
        end
    end
    assign bus.r_data = mem_q[bus.addr];
endmodule

// File: tb/tb_sync_ram.sv
// tb_sync_ram: directed literal checks plus randomized traffic against an array model.
module tb_sync_ram;
    import sync_ram_pkg::*;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    bit model_ok = 1'b0;
    bit done = 1'b0;
    data_t model [256];
    sync_ram_if bus ();
    sync_ram dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string name, input data_t got, input data_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s addr=%02h got=%02h exp=%02h", name, bus.addr, got, exp);
        end
    endtask
    always @(posedge clk) begin
        if (reset) begin
            foreach (model[i]) model[i] = '0;
            model_ok = 1'b1;
        end else if (bus.wr) begin
            model[bus.addr] = bus.w_data;
        end
    end
    always @(negedge clk) if (model_ok && !done) check("model", bus.r_data, model[bus.addr]);
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic rd(input string name, input addr_t a, input data_t exp);
        bus.addr = a;
        #1;
        check(name, bus.r_data, exp);
    endtask
    initial begin
        addr_t rst_addrs [4] = '{8'h00, 8'h01, 8'h02, 8'hFF};
        reset = 1'b1; bus.wr = 1'b0; bus.addr = '0; bus.w_data = '0;
        step();
        reset = 1'b0;
        foreach (rst_addrs[i]) rd("reset_clear", rst_addrs[i], 8'h00);
        bus.wr = 1'b1;
        bus.addr = 8'h00; bus.w_data = 8'h55; step();
        bus.addr = 8'h01; bus.w_data = 8'h56; step();
        bus.addr = 8'h02; bus.w_data = 8'h88; step(); step();
        bus.wr = 1'b0;
        rd("seq_rd0", 8'h00, 8'h55);
        rd("seq_rd1", 8'h01, 8'h56);
        rd("seq_rd2", 8'h02, 8'h88);
        bus.wr = 1'b1; bus.w_data = 8'hA5;
        rd("rdw_before", 8'h01, 8'h56);
        step();
        check("rdw_after", bus.r_data, 8'hA5);
        bus.wr = 1'b0; bus.w_data = 8'hFF;
        bus.addr = 8'h02;
        repeat (3) step();
        check("wr_gated", bus.r_data, 8'h88);
        bus.wr = 1'b1; bus.w_data = 8'h11; step();
        bus.w_data = 8'h22; step();
        bus.wr = 1'b0;
        rd("overwrite", 8'h02, 8'h22);
        bus.wr = 1'b1;
        bus.addr = 8'hFF; bus.w_data = 8'hC3; step();
        bus.addr = 8'h00; bus.w_data = 8'h3C; step();
        bus.wr = 1'b0;
        rd("bound_ff", 8'hFF, 8'hC3);
        rd("bound_00", 8'h00, 8'h3C);
        rd("bound_01", 8'h01, 8'hA5);
        reset = 1'b1; bus.wr = 1'b1; bus.addr = 8'h05; bus.w_data = 8'h77;
        step();
        reset = 1'b0; bus.wr = 1'b0;
        for (int a = 0; a <= 5; a++) rd("reset_prio", addr_t'(a), 8'h00);
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            bus.wr = $urandom_range(0, 1);
            bus.addr = $urandom_range(0, 1) ? addr_t'($urandom_range(0, 7)) : addr_t'($urandom_range(0, 255));
            bus.w_data = data_t'($urandom);
            #1;
            check("rand_comb", bus.r_data, model[bus.addr]);
            step();
        end
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_ram.md
Name: sync_ram

Overview:
- Single-port 256 x 8 random-access memory: synchronous write, asynchronous (combinational) read.
- Serves as the storage element beneath the FIFO controller, which drives address, data and write strobe directly.
- One clock domain; synchronous active-high reset clears the whole array.

Parameters:
- ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH words (256 by default).
- DATA_WIDTH, 8, bits per word.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- addr  input  ADDR_WIDTH  shared read/write address.
- w_data  input  DATA_WIDTH  write data.
- wr  input  1  write enable; 1 = write on the next rising edge, 0 = read only.
- r_data  output  DATA_WIDTH  read data, combinational from mem[addr].

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- Storage: array mem[0 .. 2**ADDR_WIDTH-1], each DATA_WIDTH bits. No other state.
- Reset:
  - At a rising edge with reset=1, every location becomes 0.
  - wr is ignored in that cycle; reset has priority over write.
  - After that edge r_data = 0 for any addr.
  - Reset asserted mid-operation (e.g. while wr=1) discards that cycle's write.
- Write: at a rising edge with reset=0 and wr=1, mem[addr] <= w_data. Other locations are unchanged.
- Read:
  - r_data = mem[addr] continuously, zero cycles of latency, regardless of wr.
  - An addr change is visible on r_data in the same cycle, with no clock needed.
- Read during write (same address):
  - Before the edge, r_data shows the old contents.
  - Immediately after the edge, r_data shows the newly written value.
  - No bypass of w_data to r_data.
- Repeated writes: wr held high with a constant addr rewrites the same location every cycle; the last w_data wins.
- Address range: the full 0 .. 2**ADDR_WIDTH-1 range is valid, with no wrap or out-of-range logic. Address 0xFF is as ordinary as 0x00.
- Power-up contents before the first reset are undefined; the bench must reset first.
- No handshake and no full/empty flags; those belong to the FIFO controller.

Decomposition:
- Shared package holds:
  - RAM_ADDR_WIDTH = 8 and RAM_DATA_WIDTH = 8 as constants.
  - addr_t and data_t typedefs, used by sync_ram and the FIFO controller.
- No sub-module: a single flat module with one clocked process (reset/write) and one continuous read assignment.

Test Plan:
- Reset: assert reset for 1 cycle, release -> r_data = 0x00 at addr 0x00, 0x01, 0x02 and 0xFF.
- Sequential write and read-back:
  - With wr=1, drive addr/w_data for 1 cycle each: 0x00/0x55, 0x01/0x56, then 0x02/0x88 for 2 cycles.
  - Drop wr, step addr 0x00, 0x01, 0x02 -> r_data 0x55, 0x56, 0x88, each in the same cycle addr changes.
- Read-during-write: at addr 0x01 (holding 0x56), wr=1, w_data=0xA5 -> r_data = 0x56 before the edge, 0xA5 after it.
- Write gating and overwrite:
  - wr=0, addr 0x02, w_data 0xFF over several edges -> r_data stays 0x88.
  - Then wr=1 for 2 cycles with w_data 0x11 then 0x22 -> r_data = 0x22.
- Boundary addresses: write 0xC3 to 0xFF and 0x3C to 0x00 -> each reads back correctly, and 0x01 is unchanged.
- Reset with contents: assert reset while wr=1, addr 0x05, w_data 0x77 -> after the edge, addr 0x00..0x05 all read 0x00.
